// File: rtl/chacha_pkg.sv
// Shared constants, state typedefs and helpers for the ChaCha block engine.
package chacha_pkg;

  localparam int N_WORDS = 16;

  // "expand 32-byte k" (256-bit key), word 0 in the low bits
  localparam logic [127:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
  // "expand 16-byte k" (128-bit key), word 0 in the low bits
  localparam logic [127:0] TAU   = {32'h6b206574, 32'h79622d36, 32'h3120646e, 32'h61707865};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_ADD   = 2'd2,
    ST_OUT   = 2'd3
  } chacha_state_e;

  // Word i of the 16-word state sits at [32i+:32]
  typedef logic [N_WORDS-1:0][31:0] chacha_blk_t;

  function automatic logic [31:0] rotl32(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // RFC 8439 initial state; a 128-bit key is repeated into both key halves
  function automatic chacha_blk_t init_state(input logic [255:0] key,
                                             input logic         key_mode,
                                             input logic [95:0]  nonce,
                                             input logic [31:0]  ctr);
    chacha_blk_t s;
    s[3:0]   = key_mode ? SIGMA : TAU;
    s[11:4]  = key_mode ? key : {key[127:0], key[127:0]};
    s[12]    = ctr;
    s[15:13] = nonce;
    return s;
  endfunction

endpackage

// File: rtl/chacha_QUARTER_ROUND.sv
// Combinational ChaCha quarter-round on four state words.
module chacha_QUARTER_ROUND
  import chacha_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic [31:0] o_c,
  output logic [31:0] o_d
);

  logic [31:0] w_a1, w_d1, w_c1, w_b1;

  assign w_a1 = i_a + i_b;
  assign w_d1 = rotl32(i_d ^ w_a1, 16);
  assign w_c1 = i_c + w_d1;
  assign w_b1 = rotl32(i_b ^ w_c1, 12);
  assign o_a  = w_a1 + w_b1;
  assign o_d  = rotl32(w_d1 ^ o_a, 8);
  assign o_c  = w_c1 + o_d;
  assign o_b  = rotl32(w_b1 ^ o_c, 7);

endmodule

// File: rtl/chacha_block_engine.sv
// ChaCha keystream block engine: one step of four parallel quarter-rounds per
// cycle, feed-forward add, then a held output until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for a request, in_ready_o high
// ROUND | one column or diagonal step per cycle, r_step counts down to 0
// ADD   | working state + initial state registered into ks_o
// OUT   | ks_o held valid until ks_ready_i; reload next counter or finish
module chacha_block_engine
  import chacha_pkg::*;
#(
  parameter int DOUBLE_ROUNDS = 10,
  parameter int BLK_CNT_BITS  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [255:0]            key_i,
  input  logic                    key_mode_i,
  input  logic [95:0]             nonce_i,
  input  logic [31:0]             counter_i,
  input  logic [BLK_CNT_BITS-1:0] nblocks_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [511:0]            ks_o,
  output logic                    ks_valid_o,
  input  logic                    ks_ready_i,
  output logic                    ks_last_o,
  output logic                    ctr_wrap_o
);

  localparam int                STEP_W    = 5;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(2 * DOUBLE_ROUNDS - 1);

  chacha_state_e r_state, w_state_nxt;
  chacha_blk_t   r_work, r_init, r_ks;
  chacha_blk_t   w_round, w_sum, w_acc_init, w_reload;
  logic [STEP_W-1:0]       r_step;
  logic [BLK_CNT_BITS-1:0] r_blk_left;
  logic                    r_wrap;
  logic                    w_diag, w_accept, w_advance, w_more;
  logic [31:0]             w_ctr_inc;
  logic [3:0]              w_ia [4], w_ib [4], w_ic [4], w_id [4];
  logic [31:0]             w_qa [4], w_qb [4], w_qc [4], w_qd [4];

  assign w_accept   = (r_state == ST_IDLE) && in_valid_i;
  assign w_more     = (r_blk_left != '0);
  assign w_advance  = (r_state == ST_OUT) && ks_ready_i && w_more;
  // r_step starts odd, so an odd r_step is an even (column) step
  assign w_diag     = ~r_step[0];
  assign w_ctr_inc  = r_init[12] + 32'd1;
  assign w_acc_init = init_state(key_i, key_mode_i, nonce_i, counter_i);

  // Word index = {row, column}; diagonals rotate the column by the row number
  for (genvar q = 0; q < 4; q++) begin : g_qr
    localparam logic [1:0] COL = 2'(q);
    assign w_ia[q] = {2'd0, COL};
    assign w_ib[q] = {2'd1, COL + (w_diag ? 2'd1 : 2'd0)};
    assign w_ic[q] = {2'd2, COL + (w_diag ? 2'd2 : 2'd0)};
    assign w_id[q] = {2'd3, COL + (w_diag ? 2'd3 : 2'd0)};

    chacha_QUARTER_ROUND u_qr (
      .i_a (r_work[w_ia[q]]),
      .i_b (r_work[w_ib[q]]),
      .i_c (r_work[w_ic[q]]),
      .i_d (r_work[w_id[q]]),
      .o_a (w_qa[q]),
      .o_b (w_qb[q]),
      .o_c (w_qc[q]),
      .o_d (w_qd[q])
    );
  end

  // Scatter quarter-round results back, build feed-forward sum and reload state
  always_comb begin
    w_round = r_work;
    for (int q = 0; q < 4; q++) begin
      w_round[w_ia[q]] = w_qa[q];
      w_round[w_ib[q]] = w_qb[q];
      w_round[w_ic[q]] = w_qc[q];
      w_round[w_id[q]] = w_qd[q];
    end
    for (int i = 0; i < N_WORDS; i++) begin
      w_sum[i] = r_work[i] + r_init[i];
    end
    w_reload     = r_init;
    w_reload[12] = w_ctr_inc;
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (in_valid_i) w_state_nxt = ST_ROUND;
      ST_ROUND: if (r_step == '0) w_state_nxt = ST_ADD;
      ST_ADD:   w_state_nxt = ST_OUT;
      ST_OUT:   if (ks_ready_i) w_state_nxt = w_more ? ST_ROUND : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: load on accept/reload, round steps, feed-forward capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_work     <= '0;
      r_init     <= '0;
      r_ks       <= '0;
      r_step     <= '0;
      r_blk_left <= '0;
      r_wrap     <= 1'b0;
    end else if (w_accept) begin
      r_init     <= w_acc_init;
      r_work     <= w_acc_init;
      r_step     <= STEP_LAST;
      r_blk_left <= nblocks_i;
      r_wrap     <= 1'b0;
    end else if (w_advance) begin
      r_init[12] <= w_ctr_inc;
      r_work     <= w_reload;
      r_step     <= STEP_LAST;
      r_blk_left <= r_blk_left - BLK_CNT_BITS'(1);
      if (w_ctr_inc == '0) r_wrap <= 1'b1;
    end else if (r_state == ST_ROUND) begin
      r_work <= w_round;
      r_step <= r_step - STEP_W'(1);
    end else if (r_state == ST_ADD) begin
      r_ks <= w_sum;
    end
  end

  assign in_ready_o = (r_state == ST_IDLE);
  assign ks_valid_o = (r_state == ST_OUT);
  assign ks_last_o  = (r_state == ST_OUT) && !w_more;
  assign ctr_wrap_o = r_wrap;
  assign ks_o       = r_ks;

endmodule

// File: doc/chacha_block_engine.md
CHACHA_BLOCK_ENGINE -- requirements
Module: chacha_block_engine

Interface
REQ-001 SHALL have parameter DOUBLE_ROUNDS, default 10, meaning double rounds per block; legal values 4, 6, 10 (ChaCha8/12/20).
REQ-002 SHALL have parameter BLK_CNT_BITS, default 8, meaning width of the multi-block count input.
REQ-003 SHALL have ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- key_i  in  256  key; word k at [32k+:32].
- key_mode_i  in  1  0 = 128-bit key (key_i[127:0]), 1 = 256-bit key.
- nonce_i  in  96  nonce; word k at [32k+:32].
- counter_i  in  32  initial block counter.
- nblocks_i  in  BLK_CNT_BITS  blocks to generate minus 1.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  engine can accept a request.
- ks_o  out  512  keystream block; word i at [32i+:32].
- ks_valid_o  out  1  ks_o valid.
- ks_ready_i  in  1  consumer accepts ks_o.
- ks_last_o  out  1  current block is the last of the request.
- ctr_wrap_o  out  1  sticky: block counter wrapped from 0xFFFFFFFF to 0 during the request.

Function
REQ-004 SHALL start a request on the edge where in_valid_i and in_ready_o are both high, registering key, key_mode, nonce, counter and nblocks.
REQ-005 SHALL build the initial state per RFC 8439: words 0-3 = constants; words 4-11 = key; word 12 = counter; words 13-15 = nonce.
REQ-006 SHALL use constants 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574 in 256-bit mode.
REQ-007 SHALL use constants 0x61707865, 0x3120646e, 0x79622d36, 0x6b206574 in 128-bit mode, with words 4-7 and 8-11 both equal to key_i[127:0].
REQ-008 SHALL implement FSM states IDLE, ROUND, ADD and OUT.
- IDLE -> ROUND on request accept.
- ROUND -> ADD after 2*DOUBLE_ROUNDS steps.
- ADD -> OUT after one cycle.
- OUT -> ROUND on ks_ready_i when blocks remain; OUT -> IDLE on ks_ready_i when none remain.
REQ-009 SHALL apply four parallel quarter-rounds per ROUND cycle: even steps on columns (0,4,8,12)...(3,7,11,15), odd steps on diagonals (0,5,10,15),(1,6,11,12),(2,7,8,13),(3,4,9,14).
REQ-010 SHALL, in ADD, register ks_o = working state + initial state, word-wise modulo 2^32 (feed-forward).
REQ-011 SHALL assert ks_valid_o exactly 2*DOUBLE_ROUNDS+1 cycles after the accept edge (21 for the default).
REQ-012 SHALL hold ks_o, ks_valid_o and ks_last_o stable while ks_valid_o=1 and ks_ready_i=0.
REQ-013 SHALL, on the edge ks_valid_o and ks_ready_i are both high with blocks remaining, reload the state with counter+1 (mod 2^32) and restart ROUND. Each subsequent block SHALL have the same 2*DOUBLE_ROUNDS+1 latency.
REQ-014 SHALL set ctr_wrap_o when the incremented counter equals 0. It SHALL stay set until the next request accept, which clears it.
REQ-015 SHALL drive in_ready_o high only in IDLE; requests outside IDLE are ignored.
REQ-016 SHALL assert ks_last_o with ks_valid_o for the final block; nblocks_i=0 yields exactly one block.

Reset
REQ-017 SHALL, on rst_i, go to IDLE with in_ready_o=1, ks_valid_o=0, ks_last_o=0, ctr_wrap_o=0 and ks_o=0, including mid-request; the pending request is discarded.
REQ-018 SHALL give in_valid_i no effect during the reset cycle.

Structure
REQ-019 SHALL take the sigma and tau constants, the state word count (16) and the FSM state encoding from shared package chacha_pkg.
REQ-020 SHALL instantiate four chacha_QUARTER_ROUND sub-modules, with column/diagonal routing as local muxing; no other sub-module.

Verification
REQ-021 RFC 8439 2.3.2 (key 00..1f, nonce 000000090000004a00000000, counter 1, 256-bit, nblocks 0) -> ks_o word0 = 0xe4e7f110, ks_valid_o at cycle 21, ks_last_o=1.
REQ-022 Same key/nonce, counter 1, nblocks 1, ks_ready_i always high -> two blocks, the second equal to the counter-2 reference, ks_last_o only on the second.
REQ-023 counter 0xFFFFFFFF, nblocks 1 -> second block uses counter 0x00000000; ctr_wrap_o=1 from the reload edge until the next accept.
REQ-024 ks_ready_i low for 10 cycles at OUT -> ks_o and ks_valid_o stable throughout, in_ready_o=0, new in_valid_i ignored.
REQ-025 rst_i pulsed at ROUND step 7 -> next cycle IDLE, in_ready_o=1, ks_valid_o=0; a fresh request then produces correct output.
REQ-026 DOUBLE_ROUNDS=4 build, key_mode_i=0, all-zero 128-bit key/nonce/counter -> matches the ChaCha8 128-bit reference block at cycle 9.
